// File: rtl/spi_regs_pkg.sv
// Shared definitions for the SPI register bank: register map addresses,
// the per-address access type and the error counter width.
package spi_regs_pkg;

    localparam int ADDR_ID       = 0;
    localparam int ADDR_STATUS   = 1;
    localparam int ADDR_CTRL     = 2;
    localparam int ADDR_ERRCNT   = 3;
    localparam int ADDR_GEN_BASE = 4;

    localparam int ERRCNT_W = 8;

    typedef enum logic [1:0] {
        ACC_RO,
        ACC_RW,
        ACC_W1C
    } acc_t;

endpackage

// File: rtl/spi_status_w1c.sv
// STATUS register with write-1-to-clear and hardware set pulses, plus the
// registered interrupt reduction against the enable mask.
// Ports:
//   master_clock  system clock
//   i_rst         asynchronous reset, active-high
//   w1c_mask      bits to clear this cycle (zero when no STATUS write)
//   set_bits      hardware set pulses; a set beats a clear on the same bit
//   irq_en        interrupt enable mask (CONTROL)
//   status        current STATUS value
//   irq           |(status & irq_en), delayed one cycle
module spi_status_w1c #(
    parameter int SPI_WORD_LEN = 16
) (
    input  logic                    master_clock,
    input  logic                    i_rst,
    input  logic [SPI_WORD_LEN-1:0] w1c_mask,
    input  logic [SPI_WORD_LEN-1:0] set_bits,
    input  logic [SPI_WORD_LEN-1:0] irq_en,
    output logic [SPI_WORD_LEN-1:0] status,
    output logic                    irq
);

    always_ff @(posedge master_clock or posedge i_rst) begin
        if (i_rst) begin
            status <= '0;
            irq    <= 1'b0;
        end else begin
            // Set is OR-ed in after the clear so it wins on a collision.
            status <= (status & ~w1c_mask) | set_bits;
            irq    <= |(status & irq_en);
        end
    end

endmodule

// File: rtl/spi_reg_bank.sv
// Register bank behind the SPI slave front-end. Decodes access strobes,
// serves reads through a held output register, and hosts ID, STATUS (W1C),
// CONTROL, a saturating error counter and general RW registers.
// Ports:
//   master_clock, i_rst            clock and asynchronous active-high reset
//   reg_operate, spi_read/write    access strobe and its qualifiers
//   spi_addr, spi_data             access address and write data
//   hw_status_set                  per-bit set pulses into STATUS
//   data_word_send                 read data, held until the next read
//   ctrl_out                       CONTROL value (IRQ enable mask)
//   irq                            registered |(STATUS & CONTROL)
//   wr_strobe, wr_addr             notification of a general-register write
module spi_reg_bank
    import spi_regs_pkg::*;
#(
    parameter int                      SPI_ADDR_LEN = 8,
    parameter int                      SPI_WORD_LEN = 16,
    parameter int                      NUM_REGS     = 16,
    parameter logic [SPI_WORD_LEN-1:0] ID_VALUE     = 16'hA55A
) (
    input  logic                    master_clock,
    input  logic                    i_rst,
    input  logic                    reg_operate,
    input  logic                    spi_read,
    input  logic                    spi_write,
    input  logic [SPI_ADDR_LEN-1:0] spi_addr,
    input  logic [SPI_WORD_LEN-1:0] spi_data,
    input  logic [SPI_WORD_LEN-1:0] hw_status_set,
    output logic [SPI_WORD_LEN-1:0] data_word_send,
    output logic [SPI_WORD_LEN-1:0] ctrl_out,
    output logic                    irq,
    output logic                    wr_strobe,
    output logic [SPI_ADDR_LEN-1:0] wr_addr
);

    function automatic acc_t acc_of(input logic [31:0] a);
        if (a == ADDR_ID || a == ADDR_ERRCNT) return ACC_RO;
        if (a == ADDR_STATUS)                 return ACC_W1C;
        return ACC_RW;
    endfunction

    function automatic logic [ERRCNT_W-1:0] sat_inc(input logic [ERRCNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    logic [SPI_WORD_LEN-1:0] gen_regs [ADDR_GEN_BASE:NUM_REGS-1];
    logic [ERRCNT_W-1:0]     errcnt;
    logic [SPI_WORD_LEN-1:0] status;
    logic [SPI_WORD_LEN-1:0] w1c_mask_p0;
    logic [SPI_WORD_LEN-1:0] rd_mux_p0;
    logic [31:0]             addr_ext;
    logic                    in_range;
    logic                    rd_p0, wr_p0, bad_p0, err_inc_p0, gen_wr_p0, ctrl_wr_p0;

    // ---- stage p0: access decode on the reg_operate strobe ----
    assign addr_ext   = 32'(spi_addr);
    assign in_range   = addr_ext < NUM_REGS;
    assign rd_p0      = reg_operate & spi_read & ~spi_write;
    assign wr_p0      = reg_operate & spi_write & ~spi_read;
    assign bad_p0     = reg_operate & (spi_read == spi_write);
    assign err_inc_p0 = bad_p0
                      | (rd_p0 & ~in_range)
                      | (wr_p0 & (~in_range | (acc_of(addr_ext) == ACC_RO)));
    assign gen_wr_p0  = wr_p0 & in_range & (addr_ext >= ADDR_GEN_BASE);
    assign ctrl_wr_p0 = wr_p0 & (addr_ext == ADDR_CTRL);
    assign w1c_mask_p0 = (wr_p0 && acc_of(addr_ext) == ACC_W1C) ? spi_data : '0;

    always_comb begin
        rd_mux_p0 = '0;
        if (in_range) begin
            if (addr_ext == ADDR_ID)          rd_mux_p0 = ID_VALUE;
            else if (addr_ext == ADDR_STATUS) rd_mux_p0 = status;
            else if (addr_ext == ADDR_CTRL)   rd_mux_p0 = ctrl_out;
            else if (addr_ext == ADDR_ERRCNT) rd_mux_p0 = {{(SPI_WORD_LEN-ERRCNT_W){1'b0}}, errcnt};
            else begin
                for (int i = ADDR_GEN_BASE; i < NUM_REGS; i++) begin
                    if (addr_ext == 32'(i)) rd_mux_p0 = gen_regs[i];
                end
            end
        end
    end

    // ---- stage p1: registered results of the access ----
    always_ff @(posedge master_clock or posedge i_rst) begin
        if (i_rst) begin
            data_word_send <= '0;
            ctrl_out       <= '0;
            errcnt         <= '0;
            wr_strobe      <= 1'b0;
            wr_addr        <= '0;
            for (int i = ADDR_GEN_BASE; i < NUM_REGS; i++) gen_regs[i] <= '0;
        end else begin
            wr_strobe <= gen_wr_p0;
            if (rd_p0)      data_word_send <= rd_mux_p0;
            if (ctrl_wr_p0) ctrl_out <= spi_data;
            if (err_inc_p0) errcnt <= sat_inc(errcnt);
            if (gen_wr_p0) begin
                wr_addr <= spi_addr;
                for (int i = ADDR_GEN_BASE; i < NUM_REGS; i++) begin
                    if (addr_ext == 32'(i)) gen_regs[i] <= spi_data;
                end
            end
        end
    end

    spi_status_w1c #(
        .SPI_WORD_LEN (SPI_WORD_LEN)
    ) u_status (
        .master_clock (master_clock),
        .i_rst        (i_rst),
        .w1c_mask     (w1c_mask_p0),
        .set_bits     (hw_status_set),
        .irq_en       (ctrl_out),
        .status       (status),
        .irq          (irq)
    );

endmodule

// File: tb/tb_spi_reg_bank.sv
module tb_spi_reg_bank;

    logic        master_clock = 1'b0;
    logic        i_rst;
    logic        reg_operate, spi_read, spi_write;
    logic [7:0]  spi_addr;
    logic [15:0] spi_data, hw_status_set;
    logic [15:0] data_word_send, ctrl_out;
    logic        irq, wr_strobe;
    logic [7:0]  wr_addr;

    always #5 master_clock = ~master_clock;

    spi_reg_bank dut (
        .master_clock   (master_clock),
        .i_rst          (i_rst),
        .reg_operate    (reg_operate),
        .spi_read       (spi_read),
        .spi_write      (spi_write),
        .spi_addr       (spi_addr),
        .spi_data       (spi_data),
        .hw_status_set  (hw_status_set),
        .data_word_send (data_word_send),
        .ctrl_out       (ctrl_out),
        .irq            (irq),
        .wr_strobe      (wr_strobe),
        .wr_addr        (wr_addr)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: register map as plain variables.
    logic [15:0] m_gen [0:15];
    logic [15:0] m_status, m_ctrl, m_rdata;
    int          m_err;
    logic        m_irq, m_wrs;
    logic [7:0]  m_wra;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_gen[i] = 16'h0;
        m_status = 0; m_ctrl = 0; m_rdata = 0; m_err = 0;
        m_irq = 0; m_wrs = 0; m_wra = 0;
    endtask

    function automatic logic [15:0] model_read(input int a);
        case (a)
            0: return 16'hA55A;
            1: return m_status;
            2: return m_ctrl;
            3: return 16'(m_err);
            default: return (a < 16) ? m_gen[a] : 16'h0;
        endcase
    endfunction

    task automatic bump_err();
        if (m_err < 255) m_err++;
    endtask

    // Apply one cycle of inputs (called at a negedge), advance, update the
    // model with the architectural rules and compare every output.
    task automatic step(input logic op, input logic rd, input logic wr,
                        input logic [7:0] a, input logic [15:0] d, input logic [15:0] s);
        logic [15:0] clr;
        int ai;
        reg_operate = op; spi_read = rd; spi_write = wr;
        spi_addr = a; spi_data = d; hw_status_set = s;
        @(negedge master_clock);
        ai = int'(a);
        clr = 16'h0;
        m_irq = |(m_status & m_ctrl);
        m_wrs = 1'b0;
        if (op) begin
            if (rd == wr) bump_err();
            else if (rd) begin
                m_rdata = model_read(ai);
                if (ai >= 16) bump_err();
            end else begin
                if (ai == 1) clr = d;
                else if (ai == 2) m_ctrl = d;
                else if (ai >= 4 && ai < 16) begin
                    m_gen[ai] = d; m_wrs = 1'b1; m_wra = a;
                end else bump_err();
            end
        end
        m_status = (m_status & ~clr) | s;
        check("rdata", data_word_send, m_rdata);
        check("ctrl_out", ctrl_out, m_ctrl);
        check("irq", irq, m_irq);
        check("wr_strobe", wr_strobe, m_wrs);
        if (m_wrs) check("wr_addr", wr_addr, m_wra);
    endtask

    task automatic idle(input logic [15:0] s);
        step(1'b0, 1'b0, 1'b0, 8'h0, 16'h0, s);
    endtask

    typedef struct {
        logic        op, rd, wr;
        logic [7:0]  addr;
        logic [15:0] data;
        logic [15:0] exp_rd;
        logic        exp_wrs;
    } vec_t;

    vec_t tbl [13];

    initial begin
        tbl[0]  = '{1'b1, 1'b1, 1'b0, 8'd0,  16'h0000, 16'hA55A, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 1'b1, 8'd5,  16'h1234, 16'hA55A, 1'b1};
        tbl[2]  = '{1'b1, 1'b1, 1'b0, 8'd5,  16'h0000, 16'h1234, 1'b0};
        tbl[3]  = '{1'b1, 1'b1, 1'b0, 8'd3,  16'h0000, 16'h0000, 1'b0};
        tbl[4]  = '{1'b1, 1'b0, 1'b1, 8'd0,  16'hFFFF, 16'h0000, 1'b0};
        tbl[5]  = '{1'b1, 1'b0, 1'b1, 8'd3,  16'hFFFF, 16'h0000, 1'b0};
        tbl[6]  = '{1'b1, 1'b1, 1'b0, 8'd16, 16'h0000, 16'h0000, 1'b0};
        tbl[7]  = '{1'b1, 1'b1, 1'b1, 8'd4,  16'h5555, 16'h0000, 1'b0};
        tbl[8]  = '{1'b1, 1'b1, 1'b0, 8'd3,  16'h0000, 16'h0004, 1'b0};
        tbl[9]  = '{1'b1, 1'b0, 1'b0, 8'd4,  16'h5555, 16'h0004, 1'b0};
        tbl[10] = '{1'b1, 1'b1, 1'b0, 8'd3,  16'h0000, 16'h0005, 1'b0};
        tbl[11] = '{1'b1, 1'b1, 1'b0, 8'd0,  16'h0000, 16'hA55A, 1'b0};
        tbl[12] = '{1'b1, 1'b0, 1'b1, 8'd15, 16'hBEEF, 16'hA55A, 1'b1};

        reg_operate = 0; spi_read = 0; spi_write = 0;
        spi_addr = 0; spi_data = 0; hw_status_set = 0;
        i_rst = 1'b1;
        model_reset();
        repeat (2) @(negedge master_clock);
        i_rst = 1'b0;

        check("rst_rdata", data_word_send, 16'h0);
        check("rst_ctrl", ctrl_out, 16'h0);
        check("rst_irq", irq, 1'b0);
        check("rst_wr_strobe", wr_strobe, 1'b0);
        check("rst_wr_addr", wr_addr, 8'h0);

        for (int i = 0; i < 13; i++) begin
            step(tbl[i].op, tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].data, 16'h0);
            check("tbl_rdata", data_word_send, tbl[i].exp_rd);
            check("tbl_wr_strobe", wr_strobe, tbl[i].exp_wrs);
            if (tbl[i].exp_wrs) check("tbl_wr_addr", wr_addr, tbl[i].addr);
        end
        step(1'b1, 1'b1, 1'b0, 8'd15, 16'h0, 16'h0);
        check("gen15_read", data_word_send, 16'hBEEF);

        // irq follows STATUS & CONTROL one cycle late
        step(1'b1, 1'b0, 1'b1, 8'd2, 16'h0004, 16'h0);
        idle(16'h0005);
        check("irq_not_yet", irq, 1'b0);
        idle(16'h0);
        check("irq_raised", irq, 1'b1);
        step(1'b1, 1'b0, 1'b1, 8'd1, 16'h0004, 16'h0);
        idle(16'h0);
        check("irq_cleared", irq, 1'b0);
        step(1'b1, 1'b1, 1'b0, 8'd1, 16'h0, 16'h0);
        check("status_after_w1c", data_word_send, 16'h0001);

        // set beats clear on the same bit
        step(1'b1, 1'b0, 1'b1, 8'd1, 16'h0002, 16'h0002);
        step(1'b1, 1'b1, 1'b0, 8'd1, 16'h0, 16'h0);
        check("set_wins", data_word_send, 16'h0003);
        // read concurrent with a set sees the old value
        step(1'b1, 1'b1, 1'b0, 8'd1, 16'h0, 16'h0008);
        check("read_before_set", data_word_send, 16'h0003);
        step(1'b1, 1'b1, 1'b0, 8'd1, 16'h0, 16'h0);
        check("read_after_set", data_word_send, 16'h000B);
        step(1'b1, 1'b0, 1'b1, 8'd1, 16'hFFFF, 16'h0);

        // randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            logic op, rd, wr;
            logic [15:0] s;
            op = ($urandom_range(0, 3) != 0);
            rd = ($urandom_range(0, 9) < 5);
            wr = ($urandom_range(0, 9) < 5);
            s  = ($urandom_range(0, 7) == 0) ? 16'(1 << $urandom_range(0, 15)) : 16'h0;
            step(op, rd, wr, 8'($urandom_range(0, 18)), 16'($urandom), s);
        end

        // error counter saturation
        for (int i = 0; i < 300; i++) step(1'b1, 1'b1, 1'b1, 8'd0, 16'h0, 16'h0);
        step(1'b1, 1'b1, 1'b0, 8'd3, 16'h0, 16'h0);
        check("errcnt_sat", data_word_send, 16'h00FF);

        // async reset in the middle of an access
        step(1'b1, 1'b0, 1'b1, 8'd5, 16'h1234, 16'h0);
        step(1'b1, 1'b0, 1'b1, 8'd2, 16'hFFFF, 16'h0);
        idle(16'h0010);
        idle(16'h0);
        step(1'b1, 1'b1, 1'b0, 8'd5, 16'h0, 16'h0);
        check("pre_rst_irq", irq, 1'b1);
        check("pre_rst_rdata", data_word_send, 16'h1234);
        reg_operate = 1; spi_read = 0; spi_write = 1; spi_addr = 8'd4; spi_data = 16'h1111;
        #2 i_rst = 1'b1;
        #1;
        check("async_ctrl", ctrl_out, 16'h0);
        check("async_irq", irq, 1'b0);
        check("async_rdata", data_word_send, 16'h0);
        @(negedge master_clock);
        i_rst = 1'b0;
        model_reset();
        step(1'b1, 1'b1, 1'b0, 8'd4, 16'h0, 16'h0);
        check("lost_write", data_word_send, 16'h0);
        step(1'b1, 1'b1, 1'b0, 8'd3, 16'h0, 16'h0);
        check("errcnt_after_rst", data_word_send, 16'h0);
        step(1'b1, 1'b1, 1'b0, 8'd0, 16'h0, 16'h0);
        check("id_after_rst", data_word_send, 16'hA55A);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
